// File: rtl/sram_read_responder_pkg.sv
// Shared types and defaults for the background-load SRAM read path.
// The loader and the responder both import this package.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE,
        REARM
    } sram_rd_state_t;

    localparam int SRAM_ADDR_W      = 20;
    localparam int SRAM_DATA_W      = 16;
    localparam int SRAM_WAIT_CYCLES = 2;
    // Wide enough for the largest legal wait (15).
    localparam int SRAM_CNT_W       = 4;

endpackage

// File: rtl/sram_read_responder_if.sv
// Loader-side handshake for single-word SRAM reads.
// The loader holds reading high until it sees SRAM_done.
interface sram_read_responder_if
    import sram_pkg::*;
#(
    parameter int ADDR_W = SRAM_ADDR_W,
    parameter int DATA_W = SRAM_DATA_W
) ();

    logic              reading;
    logic [ADDR_W-1:0] ADDR;
    logic [DATA_W-1:0] DATA_IN;
    logic              SRAM_done;
    logic              busy;

    modport master (
        output reading,
        output ADDR,
        input  DATA_IN,
        input  SRAM_done,
        input  busy
    );

    modport slave (
        input  reading,
        input  ADDR,
        output DATA_IN,
        output SRAM_done,
        output busy
    );

endinterface

// File: rtl/sram_read_responder.sv
// Read-only sequencer for the off-chip async SRAM: one word per request level,
// registered strobes/address, data captured after WAIT_CYCLES of OE_N low.
//
// state  | meaning
// IDLE   | strobes high, waiting for reading
// ACCESS | CE_N/OE_N low, counting down before DQ is sampled
// DONE   | SRAM_done pulse, DATA_IN holds the new word
// REARM  | request still high after completion; wait for it to drop
module sram_read_responder
    import sram_pkg::*;
#(
    parameter int WAIT_CYCLES = SRAM_WAIT_CYCLES,
    parameter int ADDR_W      = SRAM_ADDR_W,
    parameter int DATA_W      = SRAM_DATA_W
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    sram_read_responder_if.slave ld,
    output logic [ADDR_W-1:0]    SRAM_ADDR,
    inout  wire  [DATA_W-1:0]    SRAM_DQ,
    output logic                 SRAM_CE_N,
    output logic                 SRAM_OE_N,
    output logic                 SRAM_WE_N,
    output logic                 SRAM_UB_N,
    output logic                 SRAM_LB_N
);

    localparam logic [SRAM_CNT_W-1:0] CNT_LOAD = SRAM_CNT_W'(WAIT_CYCLES - 1);

    sram_rd_state_t          state_q, state_d;
    logic [SRAM_CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]       data_q, data_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic                    done_q, done_d;
    logic                    ce_n_q, ce_n_d;
    logic                    oe_n_q, oe_n_d;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            done_q  <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        ce_n_d  = ce_n_q;
        oe_n_d  = oe_n_q;

        unique case (state_q)
            IDLE: begin
                if (ld.reading) begin
                    state_d = ACCESS;
                    addr_d  = ld.ADDR;
                    ce_n_d  = 1'b0;
                    oe_n_d  = 1'b0;
                    cnt_d   = CNT_LOAD;
                end
            end
            ACCESS: begin
                // A dropped request abandons the access without touching DATA_IN.
                if (!ld.reading) begin
                    state_d = IDLE;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = DONE;
                    data_d  = SRAM_DQ;
                    done_d  = 1'b1;
                    ce_n_d  = 1'b1;
                    oe_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - SRAM_CNT_W'(1);
                end
            end
            DONE: begin
                state_d = ld.reading ? REARM : IDLE;
            end
            REARM: begin
                if (!ld.reading) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign SRAM_DQ      = 'z;
    assign SRAM_ADDR    = addr_q;
    assign SRAM_CE_N    = ce_n_q;
    assign SRAM_OE_N    = oe_n_q;
    assign SRAM_WE_N    = 1'b1;
    // Both byte lanes are always read, so they track chip enable.
    assign SRAM_UB_N    = ce_n_q;
    assign SRAM_LB_N    = ce_n_q;

    assign ld.DATA_IN   = data_q;
    assign ld.SRAM_done = done_q;
    assign ld.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_sram_read_responder.sv
// Directed bench for sram_read_responder: three instances (WAIT_CYCLES 2/1/4)
// against a behavioural async SRAM that drives DQ only while CE_N and OE_N are low.
module tb_sram_read_responder;
    import sram_pkg::*;

    localparam int WC [3] = '{2, 1, 4};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #10 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic        rd [3];
    logic [19:0] ad [3];
    wire  [19:0] sa [3];
    wire         ce [3];
    wire         oe [3];
    wire         we [3];
    wire         ub [3];
    wire         lb [3];
    wire         dn [3];
    wire         bz [3];
    wire  [15:0] di [3];
    int          done_cnt [3] = '{0, 0, 0};

    sram_read_responder_if ifc [3] ();

    function automatic logic [15:0] mem_word(input logic [19:0] a);
        if (a == 20'h4B000) return 16'h1234;
        return 16'hA000 | {4'h0, a[11:0]};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        wire [15:0] dq;
        assign dq = (!ce[g] && !oe[g]) ? mem_word(sa[g]) : 16'hzzzz;
        assign ifc[g].reading = rd[g];
        assign ifc[g].ADDR    = ad[g];
        assign dn[g] = ifc[g].SRAM_done;
        assign bz[g] = ifc[g].busy;
        assign di[g] = ifc[g].DATA_IN;

        sram_read_responder #(.WAIT_CYCLES(WC[g])) dut (
            .Clk       (clk),
            .Reset_n   (rst_n),
            .ld        (ifc[g]),
            .SRAM_ADDR (sa[g]),
            .SRAM_DQ   (dq),
            .SRAM_CE_N (ce[g]),
            .SRAM_OE_N (oe[g]),
            .SRAM_WE_N (we[g]),
            .SRAM_UB_N (ub[g]),
            .SRAM_LB_N (lb[g])
        );
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (dn[i] === 1'b1) done_cnt[i] <= done_cnt[i] + 1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, " DATA_IN"}, 32'(di[0]), 32'h0);
        chk({tag, " done/busy"}, 32'({dn[0], bz[0]}), 32'h0);
        chk({tag, " SRAM_ADDR"}, 32'(sa[0]), 32'h0);
        chk({tag, " strobes"}, 32'({ce[0], oe[0], we[0], ub[0], lb[0]}), 32'h1F);
    endtask

    // Called at the negedge after the accepting edge; e counts edges since acceptance.
    task automatic wait_done(input int idx, output int e, output int oe_low);
        e = 0;
        oe_low = 0;
        while (dn[idx] !== 1'b1 && e < 20) begin
            if (oe[idx] === 1'b0) oe_low++;
            @(negedge clk);
            e++;
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
    task automatic do_read(input int idx, input logic [19:0] a, input logic [15:0] exp,
                           input string tag);
        int e;
        int ol;
        rd[idx] = 1'b1;
        ad[idx] = a;
        @(negedge clk);
        chk({tag, " addr"}, 32'(sa[idx]), 32'(a));
        chk({tag, " ub/lb/ce low"}, 32'({ub[idx], lb[idx], ce[idx]}), 32'h0);
        wait_done(idx, e, ol);
        chk({tag, " latency"}, 32'(e), 32'(WC[idx]));
        chk({tag, " oe low cycles"}, 32'(ol), 32'(WC[idx]));
        chk({tag, " data"}, 32'(di[idx]), 32'(exp));
        chk({tag, " strobes at done"},
            32'({ce[idx], oe[idx], we[idx], ub[idx], lb[idx]}), 32'h1F);
        rd[idx] = 1'b0;
        @(negedge clk);
        chk({tag, " single done"}, 32'({dn[idx], bz[idx]}), 32'h0);
    endtask

    typedef struct {
        logic [19:0] addr;
        logic [15:0] data;
    } vec_t;

    initial begin
        vec_t tbl [5];
        int   exp0;
        int   e;
        int   ol;

        tbl[0] = '{20'h4B000, 16'h1234};
        tbl[1] = '{20'h00001, 16'hA001};
        tbl[2] = '{20'hFFFFF, 16'hAFFF};
        tbl[3] = '{20'h00000, 16'hA000};
        tbl[4] = '{20'h12345, 16'hA345};
        exp0 = 0;

        for (int i = 0; i < 3; i++) begin
            rd[i] = 1'b0;
            ad[i] = '0;
        end

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            do_read(0, tbl[i].addr, tbl[i].data, $sformatf("vec%0d", i));
            exp0++;
        end

        // Request held past completion must not start another access.
        rd[0] = 1'b1;
        ad[0] = 20'h4B000;
        @(negedge clk);
        wait_done(0, e, ol);
        chk("rearm first latency", 32'(e), 32'd2);
        chk("rearm first data", 32'(di[0]), 32'h1234);
        chk("rearm we_n", 32'(we[0]), 32'h1);
        exp0++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("rearm hold%0d ce/busy/done", i),
                32'({ce[0], bz[0], dn[0]}), 32'b110);
        end
        rd[0] = 1'b0;
        @(negedge clk);
        chk("rearm release busy", 32'(bz[0]), 32'h0);
        do_read(0, 20'h00001, 16'hA001, "after rearm");
        exp0++;

        // Address change after acceptance.
        rd[0] = 1'b1;
        ad[0] = 20'h4B000;
        @(negedge clk);
        ad[0] = 20'h00005;
        wait_done(0, e, ol);
        chk("addr change SRAM_ADDR", 32'(sa[0]), 32'h4B000);
        chk("addr change data", 32'(di[0]), 32'h1234);
        exp0++;
        rd[0] = 1'b0;
        @(negedge clk);
        chk("addr held after access", 32'(sa[0]), 32'h4B000);

        // Abort during ACCESS.
        rd[0] = 1'b1;
        ad[0] = 20'h00001;
        @(negedge clk);
        chk("abort in access", 32'({bz[0], oe[0]}), 32'b10);
        rd[0] = 1'b0;
        @(negedge clk);
        chk("abort done/busy/strobes", 32'({dn[0], bz[0], ce[0], oe[0], ub[0], lb[0]}),
            32'b001111);
        chk("abort DATA_IN kept", 32'(di[0]), 32'h1234);
        @(negedge clk);
        chk("abort no late done", 32'(dn[0]), 32'h0);

        // Asynchronous reset in the middle of an access.
        rd[0] = 1'b1;
        ad[0] = 20'h00001;
        @(negedge clk);
        #5;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async reset");
        rd[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_read(0, 20'h4B000, 16'h1234, "post reset");
        exp0++;

        for (int i = 0; i < 100; i++) begin
            do_read(1, 20'(i), 16'hA000 | 16'(i), $sformatf("w1 a%0d", i));
        end
        for (int i = 0; i < 100; i++) begin
            do_read(2, 20'(i), 16'hA000 | 16'(i), $sformatf("w4 a%0d", i));
        end

        repeat (3) @(negedge clk);
        chk("done count w2", 32'(done_cnt[0]), 32'(exp0));
        chk("done count w1", 32'(done_cnt[1]), 32'd100);
        chk("done count w4", 32'(done_cnt[2]), 32'd100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sram_read_responder.md
Name: sram_read_responder

Overview:
- SRAM-side responder for the background-load path. It accepts single-word read requests (level request plus 20-bit word address) from the background loader.
- It sequences the off-chip 1M x 16 async SRAM pins (CE_N/OE_N/WE_N/UB_N/LB_N, ADDR, DQ) and returns the 16-bit word with a one-cycle done pulse.
- It sits between the loader and the top-level SRAM pins. It is read-only; WE_N is held high.

Parameters:
- WAIT_CYCLES, 2, Clk cycles OE_N is held low before DQ is sampled (legal range 1..15).
- ADDR_W, 20, SRAM word-address width.
- DATA_W, 16, SRAM data width.

Ports:
- Clk  input  1  system clock (50 MHz)
- Reset_n  input  1  asynchronous, active-low reset
- reading  input  1  read request level from loader; held high until SRAM_done seen
- ADDR  input  ADDR_W  word address; sampled only on request acceptance
- DATA_IN  output  DATA_W  captured read data; holds last captured word
- SRAM_done  output  1  one-cycle pulse: DATA_IN valid for the accepted request
- busy  output  1  high in any state other than IDLE
- SRAM_ADDR  output  ADDR_W  registered address to SRAM pins
- SRAM_DQ  inout  DATA_W  SRAM data bus; never driven by this block (constant high-Z)
- SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N  output  1 each  SRAM strobes, all registered

Behaviour:
- Reset (asynchronous, Reset_n=0):
  - state=IDLE; counter=0.
  - DATA_IN=0; SRAM_done=0; busy=0; SRAM_ADDR=0.
  - CE_N=1, OE_N=1, WE_N=1, UB_N=1, LB_N=1.
  - All of the above apply immediately, including mid-access; no done pulse is produced for an interrupted access.
- Fixed rules: WE_N is always 1. UB_N/LB_N are low exactly when CE_N is low. DQ is always 'z.
- States (shared enum): IDLE, ACCESS, DONE, REARM.
- IDLE:
  - reading=1 at a rising edge -> ACCESS.
  - Same edge: SRAM_ADDR<=ADDR; CE_N/OE_N/UB_N/LB_N<=0; counter<=WAIT_CYCLES-1.
- ACCESS:
  - reading=0 at an edge -> abort: IDLE, strobes high, DATA_IN unchanged, no SRAM_done.
  - Else if counter==0 -> DONE: DATA_IN<=SRAM_DQ, SRAM_done<=1, strobes<=1.
  - Else counter<=counter-1.
- DONE (SRAM_done high for exactly this one cycle):
  - At the edge: SRAM_done<=0.
  - reading=0 -> IDLE; reading=1 -> REARM.
- REARM:
  - Stays until reading=0, then -> IDLE.
  - Guarantees one read per request level; a request must drop for at least one edge before the next is accepted.
- Latency: request accepted at edge k; SRAM_done=1 and DATA_IN valid after edge k+WAIT_CYCLES; OE_N low for exactly WAIT_CYCLES cycles. With the default (2), done is high 2 edges after acceptance.
- ADDR changes after acceptance have no effect on the access in flight. SRAM_ADDR holds its value after the access (no glitching to 0).
- DATA_IN changes only on the DONE transition.
- Address arithmetic: none. ADDR is passed through unmodified; all 20-bit values are legal, including 0xFFFFF.
- busy = (state != IDLE), decoded from the registered state.

Decomposition:
- sram_pkg holds:
  - typedef enum logic [1:0] {IDLE, ACCESS, DONE, REARM} sram_rd_state_t
  - localparams SRAM_ADDR_W=20, SRAM_DATA_W=16
  - WAIT_CYCLES default, shared with the loader.
- No sub-module. The wait counter and pin registers are small enough to live inline.

Test Plan:
- Default params, SRAM model returns 16'h1234 at addr 20'h4B000. Hold reading=1 with ADDR=20'h4B000:
  - SRAM_ADDR=20'h4B000 and OE_N=0 after acceptance edge k.
  - SRAM_done=1 for exactly one cycle after edge k+2, with DATA_IN=16'h1234.
  - WE_N=1 throughout.
- Keep reading=1 for 5 cycles after done -> no second access (CE_N stays 1, state REARM). Drop reading 1 cycle, raise with ADDR=1 -> new read returns mem[1].
- Change ADDR to 20'h00005 one cycle after acceptance -> SRAM_ADDR stays 20'h4B000 and DATA_IN=mem[20'h4B000].
- Drop reading during ACCESS -> no SRAM_done, DATA_IN retains the prior value, strobes high the next cycle, busy=0.
- Assert Reset_n=0 asynchronously mid-ACCESS -> all outputs return to reset values without waiting for a clock edge; the first request after release completes normally.
- WAIT_CYCLES=1 and WAIT_CYCLES=4 with 100 back-to-back loader-style reads over addresses 0..99 -> every DATA_IN matches the model, done latency is exactly WAIT_CYCLES edges, and there are no extra done pulses.
